// File: rtl/edp_slice_param_if.sv
// Fast-memory and EBUS signal group of one EDP slice.
// The control side (master) addresses the FM and selects the EBUS source; the slice (slave) answers.
interface edp_slice_param_if #(
   parameter int WIDTH     = 6,
   parameter int FM_BLOCKS = 8
);
   localparam int BLK_W = (FM_BLOCKS > 1) ? $clog2(FM_BLOCKS) : 1;

   logic [3:0]       apr_fm_adr;
   logic [BLK_W-1:0] apr_fm_block;
   logic             con_fm_write_l;
   logic             diag_fm_par_inv_h;
   logic             fm_par_err_clr_h;
   logic [WIDTH-1:0] fm_data_h;
   logic             fm_parity_h;
   logic             fm_par_err_h;
   logic             ctl_ad_to_ebus_h;
   logic             diag_read_h;
   logic [2:0]       diag_sel;
   logic [WIDTH-1:0] ebus_d_h;

   modport master (
      output apr_fm_adr, apr_fm_block, con_fm_write_l, diag_fm_par_inv_h,
             fm_par_err_clr_h, ctl_ad_to_ebus_h, diag_read_h, diag_sel,
      input  fm_data_h, fm_parity_h, fm_par_err_h, ebus_d_h
   );

   modport slave (
      input  apr_fm_adr, apr_fm_block, con_fm_write_l, diag_fm_par_inv_h,
             fm_par_err_clr_h, ctl_ad_to_ebus_h, diag_read_h, diag_sel,
      output fm_data_h, fm_parity_h, fm_par_err_h, ebus_d_h
   );
endinterface

// File: rtl/edp_slice_param.sv
// WIDTH-bit EBOX data-path slice: AR/ARX/BR/BRX/MQ, adder with carry look-ahead,
// parity-protected fast-memory AC store and EBUS driver.
module edp_slice_param #(
   parameter int WIDTH     = 6,
   parameter int FM_BLOCKS = 8,
   parameter int FM_ACS    = 16
) (
   input  logic             clk_edp_h,
   input  logic             reset_l,
   input  logic [WIDTH-1:0] cache_data_h,
   input  logic [WIDTH-1:0] sh_h,
   input  logic [WIDTH-1:0] armm_h,
   input  logic [WIDTH-1:0] vma_pc_h,
   input  logic [1:0]       ctl_ar_sel,
   input  logic             ctl_ar_load_l,
   input  logic             ctl_ar_clr_h,
   input  logic [1:0]       ctl_arx_sel,
   input  logic             ctl_arx_load_h,
   input  logic             cram_br_load_h,
   input  logic             cram_brx_load_h,
   input  logic [1:0]       ctl_mq_sel,
   input  logic             mq_sin_h,
   output logic             mq_sout_h,
   input  logic [1:0]       cram_ada_sel,
   input  logic             cram_ada_dis_h,
   input  logic [1:0]       cram_adb_sel,
   input  logic [2:0]       cram_ad_func,
   input  logic             ad_cin_h,
   output logic [WIDTH-1:0] ad_h,
   output logic             ad_cout_h,
   output logic             ad_cg_h,
   output logic             ad_cp_h,
   output logic             ad_overflow_l,
   output logic             ad_eq0_l,
   output logic [WIDTH-1:0] ar_h,
   output logic [WIDTH-1:0] arx_h,
   output logic [WIDTH-1:0] br_h,
   output logic [WIDTH-1:0] brx_h,
   output logic [WIDTH-1:0] mq_h,
   edp_slice_param_if.slave bus
);

   localparam int DEPTH  = FM_BLOCKS * FM_ACS;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      FN_ADD  = 3'd0,
      FN_SUB  = 3'd1,
      FN_AND  = 3'd2,
      FN_OR   = 3'd3,
      FN_XOR  = 3'd4,
      FN_A    = 3'd5,
      FN_B    = 3'd6,
      FN_NOTA = 3'd7
   } ad_func_e;

   ad_func_e         ad_func;
   logic [WIDTH-1:0] a_side, b_side, b_eff;
   logic [WIDTH:0]   sum_full, sum_gen;
   logic             carry_msb;

   logic [ADDR_W-1:0] fm_addr;
   logic [WIDTH-1:0]  fm_mem [DEPTH];
   logic              fm_par_mem [DEPTH];
   logic [DEPTH-1:0]  fm_valid;
   logic [WIDTH-1:0]  fm_data_q;
   logic              fm_parity_q, fm_par_err_q, fm_chk_err;

   assign ad_func = ad_func_e'(cram_ad_func);

   always_comb begin
      a_side = '0;
      if (!cram_ada_dis_h) begin
         case (cram_ada_sel)
            2'd0:    a_side = ar_h;
            2'd1:    a_side = arx_h;
            2'd2:    a_side = mq_h;
            default: a_side = vma_pc_h;
         endcase
      end
      case (cram_adb_sel)
         2'd0:    b_side = br_h;
         2'd1:    b_side = brx_h;
         2'd2:    b_side = {ar_h[WIDTH-2:0], ad_cin_h};
         default: b_side = ~br_h;
      endcase
   end

   // The generate term is the same sum with carry-in forced off, so a look-ahead
   // unit can combine slices without waiting on this slice's carry-in.
   always_comb begin
      b_eff         = (ad_func == FN_SUB) ? ~b_side : b_side;
      sum_full      = {1'b0, a_side} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ad_cin_h};
      sum_gen       = {1'b0, a_side} + {1'b0, b_eff};
      carry_msb     = a_side[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];
      ad_h          = '0;
      ad_cout_h     = 1'b0;
      ad_cg_h       = 1'b0;
      ad_cp_h       = 1'b0;
      ad_overflow_l = 1'b1;
      case (ad_func)
         FN_ADD, FN_SUB: begin
            ad_h          = sum_full[WIDTH-1:0];
            ad_cout_h     = sum_full[WIDTH];
            ad_cg_h       = sum_gen[WIDTH];
            ad_cp_h       = &(a_side ^ b_eff);
            ad_overflow_l = ~(carry_msb ^ sum_full[WIDTH]);
         end
         FN_AND:  ad_h = a_side & b_side;
         FN_OR:   ad_h = a_side | b_side;
         FN_XOR:  ad_h = a_side ^ b_side;
         FN_A:    ad_h = a_side;
         FN_B:    ad_h = b_side;
         default: ad_h = ~a_side;
      endcase
   end

   assign ad_eq0_l = |ad_h;

   always_comb begin
      case (ctl_mq_sel)
         2'd2:    mq_sout_h = mq_h[WIDTH-1];
         2'd3:    mq_sout_h = mq_h[0];
         default: mq_sout_h = 1'b0;
      endcase
   end

   always_ff @(posedge clk_edp_h or negedge reset_l) begin
      if (!reset_l) begin
         ar_h  <= '0;
         arx_h <= '0;
         br_h  <= '0;
         brx_h <= '0;
         mq_h  <= '0;
      end else begin
         if (ctl_ar_clr_h) begin
            ar_h <= '0;
         end else if (!ctl_ar_load_l) begin
            case (ctl_ar_sel)
               2'd0:    ar_h <= ad_h;
               2'd1:    ar_h <= cache_data_h;
               2'd2:    ar_h <= armm_h;
               default: ar_h <= sh_h;
            endcase
         end
         if (ctl_arx_load_h) begin
            case (ctl_arx_sel)
               2'd0:    arx_h <= ad_h;
               2'd1:    arx_h <= cache_data_h;
               2'd2:    arx_h <= ar_h;
               default: arx_h <= mq_h;
            endcase
         end
         if (cram_br_load_h)  br_h  <= ar_h;
         if (cram_brx_load_h) brx_h <= arx_h;
         case (ctl_mq_sel)
            2'd1:    mq_h <= ad_h;
            2'd2:    mq_h <= {mq_h[WIDTH-2:0], mq_sin_h};
            2'd3:    mq_h <= {mq_sin_h, mq_h[WIDTH-1:1]};
            default: mq_h <= mq_h;
         endcase
      end
   end

   assign fm_addr = ADDR_W'({bus.apr_fm_block, bus.apr_fm_adr});

   // The array itself has no reset; the valid bits decide whether a word exists.
   always_ff @(posedge clk_edp_h) begin
      if (!bus.con_fm_write_l && reset_l) begin
         fm_mem[fm_addr]     <= ar_h;
         fm_par_mem[fm_addr] <= (~^ar_h) ^ bus.diag_fm_par_inv_h;
      end
   end

   assign fm_chk_err = ~^{fm_data_q, fm_parity_q};

   always_ff @(posedge clk_edp_h or negedge reset_l) begin
      if (!reset_l) begin
         fm_valid     <= '0;
         fm_data_q    <= '0;
         fm_parity_q  <= 1'b1;
         fm_par_err_q <= 1'b0;
      end else begin
         if (!bus.con_fm_write_l) fm_valid[fm_addr] <= 1'b1;
         if (fm_valid[fm_addr]) begin
            fm_data_q   <= fm_mem[fm_addr];
            fm_parity_q <= fm_par_mem[fm_addr];
         end else begin
            fm_data_q   <= '0;
            fm_parity_q <= 1'b1;
         end
         if (fm_chk_err)                 fm_par_err_q <= 1'b1;
         else if (bus.fm_par_err_clr_h)  fm_par_err_q <= 1'b0;
      end
   end

   assign bus.fm_data_h    = fm_data_q;
   assign bus.fm_parity_h  = fm_parity_q;
   assign bus.fm_par_err_h = fm_par_err_q;

   always_comb begin
      bus.ebus_d_h = '0;
      if (bus.ctl_ad_to_ebus_h) begin
         bus.ebus_d_h = ad_h;
      end else if (bus.diag_read_h) begin
         case (bus.diag_sel)
            3'd0:    bus.ebus_d_h = ar_h;
            3'd1:    bus.ebus_d_h = arx_h;
            3'd2:    bus.ebus_d_h = br_h;
            3'd3:    bus.ebus_d_h = brx_h;
            3'd4:    bus.ebus_d_h = mq_h;
            3'd5:    bus.ebus_d_h = fm_data_q;
            3'd6:    bus.ebus_d_h = {{(WIDTH-2){1'b0}}, fm_par_err_q, fm_parity_q};
            default: bus.ebus_d_h = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_edp_slice_param.sv
// Scoreboard bench for edp_slice_param at WIDTH=6, FM_BLOCKS=8.
module tb_edp_slice_param;
   localparam int W   = 6;
   localparam int FMB = 8;

   logic         clk_edp_h = 1'b0;
   logic         reset_l   = 1'b1;
   logic [W-1:0] cache_data_h, sh_h, armm_h, vma_pc_h;
   logic [1:0]   ctl_ar_sel, ctl_arx_sel, ctl_mq_sel, cram_ada_sel, cram_adb_sel;
   logic         ctl_ar_load_l, ctl_ar_clr_h, ctl_arx_load_h, cram_br_load_h, cram_brx_load_h;
   logic         mq_sin_h, mq_sout_h, cram_ada_dis_h, ad_cin_h;
   logic [2:0]   cram_ad_func;
   logic [W-1:0] ad_h, ar_h, arx_h, br_h, brx_h, mq_h;
   logic         ad_cout_h, ad_cg_h, ad_cp_h, ad_overflow_l, ad_eq0_l;

   edp_slice_param_if #(.WIDTH(W), .FM_BLOCKS(FMB)) bus ();

   edp_slice_param #(.WIDTH(W), .FM_BLOCKS(FMB), .FM_ACS(16)) dut (
      .clk_edp_h(clk_edp_h), .reset_l(reset_l),
      .cache_data_h(cache_data_h), .sh_h(sh_h), .armm_h(armm_h), .vma_pc_h(vma_pc_h),
      .ctl_ar_sel(ctl_ar_sel), .ctl_ar_load_l(ctl_ar_load_l), .ctl_ar_clr_h(ctl_ar_clr_h),
      .ctl_arx_sel(ctl_arx_sel), .ctl_arx_load_h(ctl_arx_load_h),
      .cram_br_load_h(cram_br_load_h), .cram_brx_load_h(cram_brx_load_h),
      .ctl_mq_sel(ctl_mq_sel), .mq_sin_h(mq_sin_h), .mq_sout_h(mq_sout_h),
      .cram_ada_sel(cram_ada_sel), .cram_ada_dis_h(cram_ada_dis_h),
      .cram_adb_sel(cram_adb_sel), .cram_ad_func(cram_ad_func), .ad_cin_h(ad_cin_h),
      .ad_h(ad_h), .ad_cout_h(ad_cout_h), .ad_cg_h(ad_cg_h), .ad_cp_h(ad_cp_h),
      .ad_overflow_l(ad_overflow_l), .ad_eq0_l(ad_eq0_l),
      .ar_h(ar_h), .arx_h(arx_h), .br_h(br_h), .brx_h(brx_h), .mq_h(mq_h),
      .bus(bus.slave)
   );

   always #5 clk_edp_h = ~clk_edp_h;

   typedef struct {
      string       tag;
      logic [35:0] value;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] a_op, b_op, b_eff;
   logic [2:0]   f_op;
   logic         c_op;
   logic [1:0]   bs_op;
   logic [W:0]   model_sum;
   int           pick;

   task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0o, expected %0o", tag, obs, exp);
      end
   endtask

   task automatic expectVal(input string tag, input logic [35:0] v);
      sb_entry_t e;
      e.tag   = tag;
      e.value = v;
      sb_q.push_back(e);
   endtask

   task automatic popCheck(input logic [35:0] obs);
      sb_entry_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL sb_underflow: got empty queue, expected an entry");
      end else begin
         e = sb_q.pop_front();
         checkOutput(e.tag, obs, e.value);
      end
   endtask

   task automatic tick();
      @(posedge clk_edp_h);
      #2;
   endtask

   task automatic applyStimulus(input logic [1:0] ada, input logic [1:0] adb,
                                input logic [2:0] func, input logic cin);
      cram_ada_sel = ada;
      cram_adb_sel = adb;
      cram_ad_func = func;
      ad_cin_h     = cin;
   endtask

   task automatic loadAr(input logic [1:0] sel, input logic [W-1:0] v);
      ctl_ar_sel    = sel;
      cache_data_h  = v;
      armm_h        = v;
      sh_h          = v;
      ctl_ar_load_l = 1'b0;
      tick();
      ctl_ar_load_l = 1'b1;
   endtask

   task automatic loadBr();
      cram_br_load_h = 1'b1;
      tick();
      cram_br_load_h = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cache_data_h = '0; sh_h = '0; armm_h = '0; vma_pc_h = '0;
      ctl_ar_sel = '0; ctl_ar_load_l = 1'b1; ctl_ar_clr_h = 1'b0;
      ctl_arx_sel = '0; ctl_arx_load_h = 1'b0; cram_br_load_h = 1'b0; cram_brx_load_h = 1'b0;
      ctl_mq_sel = '0; mq_sin_h = 1'b0; cram_ada_dis_h = 1'b0;
      applyStimulus(2'd0, 2'd0, 3'd0, 1'b0);
      bus.apr_fm_adr = '0; bus.apr_fm_block = '0; bus.con_fm_write_l = 1'b1;
      bus.diag_fm_par_inv_h = 1'b0; bus.fm_par_err_clr_h = 1'b0;
      bus.ctl_ad_to_ebus_h = 1'b0; bus.diag_read_h = 1'b0; bus.diag_sel = '0;

      #1 reset_l = 1'b0;
      #2;
      expectVal("rst_ar", 0); expectVal("rst_mq", 0); expectVal("rst_fm_data", 0);
      expectVal("rst_fm_parity", 1); expectVal("rst_par_err", 0);
      popCheck(ar_h); popCheck(mq_h); popCheck(bus.fm_data_h);
      popCheck(bus.fm_parity_h); popCheck(bus.fm_par_err_h);
      @(negedge clk_edp_h) reset_l = 1'b1;
      tick();

      loadAr(2'd1, 6'o12);
      expectVal("ar_from_cache", 6'o12); #1 popCheck(ar_h);
      loadBr();
      expectVal("br_from_ar", 6'o12); #1 popCheck(br_h);

      applyStimulus(2'd0, 2'd0, 3'd0, 1'b0);
      expectVal("add_ad", 6'o24); expectVal("add_cout", 0); expectVal("add_eq0_l", 1);
      #1 popCheck(ad_h); popCheck(ad_cout_h); popCheck(ad_eq0_l);

      applyStimulus(2'd0, 2'd0, 3'd1, 1'b1);
      expectVal("sub_ad", 0); expectVal("sub_eq0_l", 0); expectVal("sub_cout", 1); expectVal("sub_cp", 1);
      #1 popCheck(ad_h); popCheck(ad_eq0_l); popCheck(ad_cout_h); popCheck(ad_cp_h);

      cram_ada_dis_h = 1'b1;
      applyStimulus(2'd0, 2'd0, 3'd5, 1'b0);
      expectVal("ada_dis", 0); #1 popCheck(ad_h);
      cram_ada_dis_h = 1'b0;

      ctl_ar_clr_h = 1'b1;
      loadAr(2'd1, 6'o12);
      ctl_ar_clr_h = 1'b0;
      expectVal("ar_clr_priority", 0); #1 popCheck(ar_h);
      loadBr();

      vma_pc_h = 6'o77;
      applyStimulus(2'd3, 2'd0, 3'd0, 1'b1);
      expectVal("chain_ad", 0); expectVal("chain_cout", 1); expectVal("chain_cg", 0); expectVal("chain_cp", 1);
      #1 popCheck(ad_h); popCheck(ad_cout_h); popCheck(ad_cg_h); popCheck(ad_cp_h);

      loadAr(2'd2, 6'o40);
      loadBr();
      applyStimulus(2'd0, 2'd0, 3'd0, 1'b0);
      expectVal("ovf_ad", 0); expectVal("ovf_overflow_l", 0); expectVal("ovf_cout", 1); expectVal("ovf_cg", 1);
      #1 popCheck(ad_h); popCheck(ad_overflow_l); popCheck(ad_cout_h); popCheck(ad_cg_h);

      for (int i = 0; i < 12; i++) begin
         a_op = W'($urandom);
         b_op = W'($urandom);
         f_op = 3'($urandom_range(0, 7));
         c_op = 1'($urandom_range(0, 1));
         pick = $urandom_range(0, 2);
         bs_op = (pick == 0) ? 2'd0 : (pick == 1) ? 2'd2 : 2'd3;
         loadAr(2'd1, b_op);
         loadBr();
         vma_pc_h = a_op;
         applyStimulus(2'd3, bs_op, f_op, c_op);
         b_eff = (bs_op == 2'd0) ? b_op : (bs_op == 2'd2) ? {b_op[W-2:0], c_op} : ~b_op;
         case (f_op)
            3'd0:    model_sum = {1'b0, a_op} + {1'b0, b_eff} + {{W{1'b0}}, c_op};
            3'd1:    model_sum = {1'b0, a_op} + {1'b0, ~b_eff} + {{W{1'b0}}, c_op};
            3'd2:    model_sum = {1'b0, a_op & b_eff};
            3'd3:    model_sum = {1'b0, a_op | b_eff};
            3'd4:    model_sum = {1'b0, a_op ^ b_eff};
            3'd5:    model_sum = {1'b0, a_op};
            3'd6:    model_sum = {1'b0, b_eff};
            default: model_sum = {1'b0, ~a_op};
         endcase
         expectVal($sformatf("rand%0d_f%0d_ad", i, f_op), model_sum[W-1:0]);
         expectVal($sformatf("rand%0d_f%0d_cout", i, f_op), model_sum[W]);
         #1 popCheck(ad_h); popCheck(ad_cout_h);
      end

      vma_pc_h   = 6'o01;
      applyStimulus(2'd3, 2'd0, 3'd5, 1'b0);
      ctl_mq_sel = 2'd1;
      expectVal("mq_sout_load", 0); #1 popCheck(mq_sout_h);
      tick();
      expectVal("mq_load", 6'o01); #1 popCheck(mq_h);
      ctl_mq_sel = 2'd2;
      mq_sin_h   = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k == 6) begin
            expectVal("mq_sout_left6", 1); #1 popCheck(mq_sout_h);
         end
         tick();
      end
      expectVal("mq_left_x6", 0); #1 popCheck(mq_h);
      ctl_mq_sel = 2'd3;
      mq_sin_h   = 1'b1;
      tick(); tick(); tick();
      ctl_mq_sel = 2'd0;
      mq_sin_h   = 1'b0;
      expectVal("mq_right_x3", 6'o70); expectVal("mq_sout_hold", 0);
      #1 popCheck(mq_h); popCheck(mq_sout_h);
      ctl_mq_sel = 2'd2;
      expectVal("mq_sout_left_msb", 1); #1 popCheck(mq_sout_h);
      ctl_mq_sel = 2'd0;

      ctl_arx_sel = 2'd3; ctl_arx_load_h = 1'b1;
      tick();
      ctl_arx_load_h = 1'b0;
      expectVal("arx_from_mq", 6'o70); #1 popCheck(arx_h);
      cram_brx_load_h = 1'b1;
      tick();
      cram_brx_load_h = 1'b0;
      expectVal("brx_from_arx", 6'o70); #1 popCheck(brx_h);

      loadAr(2'd1, 6'o55);
      bus.apr_fm_block = 3'd3; bus.apr_fm_adr = 4'd7; bus.con_fm_write_l = 1'b0;
      tick();
      bus.con_fm_write_l = 1'b1;
      expectVal("fm_rd_during_first_wr", 0); #1 popCheck(bus.fm_data_h);
      tick();
      expectVal("fm_rd_55", 6'o55); expectVal("fm_par_55", 1);
      #1 popCheck(bus.fm_data_h); popCheck(bus.fm_parity_h);

      loadAr(2'd1, 6'o21);
      bus.con_fm_write_l = 1'b0;
      tick();
      bus.con_fm_write_l = 1'b1;
      expectVal("fm_rd_old_on_wr", 6'o55); #1 popCheck(bus.fm_data_h);
      tick();
      expectVal("fm_rd_new", 6'o21); expectVal("fm_par_21", 1);
      #1 popCheck(bus.fm_data_h); popCheck(bus.fm_parity_h);

      bus.apr_fm_block = 3'd0; bus.apr_fm_adr = 4'd0;
      tick();
      expectVal("fm_unwritten_data", 0); expectVal("fm_unwritten_par", 1);
      #1 popCheck(bus.fm_data_h); popCheck(bus.fm_parity_h);
      tick();
      expectVal("fm_unwritten_no_err", 0); #1 popCheck(bus.fm_par_err_h);

      bus.apr_fm_block = 3'd1; bus.apr_fm_adr = 4'd2;
      bus.con_fm_write_l = 1'b0; bus.diag_fm_par_inv_h = 1'b1;
      tick();
      bus.con_fm_write_l = 1'b1; bus.diag_fm_par_inv_h = 1'b0;
      tick();
      expectVal("fm_bad_parity", 0); expectVal("fm_err_not_yet", 0);
      #1 popCheck(bus.fm_parity_h); popCheck(bus.fm_par_err_h);
      tick();
      expectVal("fm_err_set", 1); #1 popCheck(bus.fm_par_err_h);
      bus.apr_fm_block = 3'd3; bus.apr_fm_adr = 4'd7;
      tick();
      tick();
      expectVal("fm_err_sticky", 1); #1 popCheck(bus.fm_par_err_h);
      bus.fm_par_err_clr_h = 1'b1;
      tick();
      bus.fm_par_err_clr_h = 1'b0;
      expectVal("fm_err_cleared", 0); #1 popCheck(bus.fm_par_err_h);
      bus.apr_fm_block = 3'd1; bus.apr_fm_adr = 4'd2;
      tick();
      bus.fm_par_err_clr_h = 1'b1;
      tick();
      bus.fm_par_err_clr_h = 1'b0;
      expectVal("fm_err_set_wins", 1); #1 popCheck(bus.fm_par_err_h);

      bus.diag_read_h = 1'b1;
      bus.diag_sel    = 3'd6;
      expectVal("ebus_diag_par", 6'o02); #1 popCheck(bus.ebus_d_h);
      bus.diag_sel = 3'd5;
      expectVal("ebus_diag_fm", 6'o21); #1 popCheck(bus.ebus_d_h);
      bus.diag_sel = 3'd4;
      expectVal("ebus_diag_mq", 6'o70); #1 popCheck(bus.ebus_d_h);
      vma_pc_h = 6'o33;
      applyStimulus(2'd3, 2'd0, 3'd5, 1'b0);
      bus.ctl_ad_to_ebus_h = 1'b1;
      expectVal("ebus_ad_wins", 6'o33); #1 popCheck(bus.ebus_d_h);
      bus.ctl_ad_to_ebus_h = 1'b0;
      bus.diag_sel = 3'd0;
      expectVal("ebus_diag_ar", 6'o21); #1 popCheck(bus.ebus_d_h);
      bus.diag_read_h = 1'b0;
      expectVal("ebus_idle", 0); #1 popCheck(bus.ebus_d_h);

      tick();
      reset_l = 1'b0;
      #1;
      expectVal("midrst_ar", 0); expectVal("midrst_arx", 0); expectVal("midrst_br", 0);
      expectVal("midrst_brx", 0); expectVal("midrst_mq", 0); expectVal("midrst_par_err", 0);
      expectVal("midrst_fm_parity", 1);
      popCheck(ar_h); popCheck(arx_h); popCheck(br_h); popCheck(brx_h); popCheck(mq_h);
      popCheck(bus.fm_par_err_h); popCheck(bus.fm_parity_h);
      @(negedge clk_edp_h) reset_l = 1'b1;
      bus.apr_fm_block = 3'd3; bus.apr_fm_adr = 4'd7;
      tick();
      expectVal("fm_valid_cleared", 0); #1 popCheck(bus.fm_data_h);

      checkOutput("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
